// File: rtl/collision_monitor.sv
`default_nettype none
// ============================================================================
// Module      : collision_monitor
// Description : Decides plane collisions against the lava drop and two
//               mountains once per frame tick, tracks lives, runs a post-hit
//               invulnerability window and the game-state FSM. Drives
//               game_over, which freezes the mover modules.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   system clock
//   resetn        in   1   asynchronous active-low reset
//   tick          in   1   one-cycle frame strobe
//   start         in   1   one-cycle start request
//   plane_y       in  10   plane top y
//   lava_x        in  10   lava drop left x
//   mountain1_x/y in  10   mountain 1 left x / top y
//   mountain2_x/y in  10   mountain 2 left x / top y
//   game_over     out  1   1 while IDLE or OVER (movers frozen)
//   state         out  2   0 IDLE, 1 PLAY, 2 GRACE, 3 OVER
//   lives         out  2   remaining lives
//   hit           out  1   one-cycle pulse per accepted hit
//   hit_src       out  2   bit0 lava, bit1 mountain, of the last accepted hit
//   invuln        out  1   1 while in GRACE
// ============================================================================
module collision_monitor #(
    parameter int PLANE_X     = 60,
    parameter int PLANE_W     = 40,
    parameter int PLANE_H     = 24,
    parameter int LAVA_Y      = 300,
    parameter int LAVA_W      = 16,
    parameter int LAVA_H      = 16,
    parameter int MTN_W       = 40,
    parameter int LIVES       = 3,
    parameter int GRACE_TICKS = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] plane_y,
    input  logic [9:0] lava_x,
    input  logic [9:0] mountain1_x,
    input  logic [9:0] mountain1_y,
    input  logic [9:0] mountain2_x,
    input  logic [9:0] mountain2_y,
    output logic       game_over,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic       hit,
    output logic [1:0] hit_src,
    output logic       invuln
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_GRACE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Geometry in 11 bits so right/bottom edges never wrap.
    localparam logic [10:0] c_PLANE_L = 11'(PLANE_X);
    localparam logic [10:0] c_PLANE_R = 11'(PLANE_X + PLANE_W);
    localparam logic [10:0] c_PLANE_H = 11'(PLANE_H);
    localparam logic [10:0] c_LAVA_T  = 11'(LAVA_Y);
    localparam logic [10:0] c_LAVA_B  = 11'(LAVA_Y + LAVA_H);
    localparam logic [10:0] c_LAVA_W  = 11'(LAVA_W);
    localparam logic [10:0] c_MTN_W   = 11'(MTN_W);
    localparam logic [1:0]  c_LIVES   = 2'(LIVES);

    localparam int                 c_CNT_W = $clog2(GRACE_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_GRACE = c_CNT_W'(GRACE_TICKS);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t             r_state;
    logic               r_game_over;
    logic [1:0]         r_lives;
    logic               r_hit;
    logic [1:0]         r_hit_src;
    logic               r_invuln;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_coll_q;
    logic [1:0]         r_src_q;

    logic [10:0] w_plane_top;
    logic [10:0] w_plane_bot;
    logic        w_lava;
    logic        w_m1;
    logic        w_m2;

    // Strict inequalities: objects that only touch edges do not collide.
    function automatic logic x_overlap(input logic [10:0] ox, input logic [10:0] ow);
        return (ox < c_PLANE_R) && ((ox + ow) > c_PLANE_L);
    endfunction

    assign w_plane_top = {1'b0, plane_y};
    assign w_plane_bot = w_plane_top + c_PLANE_H;

    assign w_lava = x_overlap({1'b0, lava_x}, c_LAVA_W)
                    && (w_plane_top < c_LAVA_B) && (w_plane_bot > c_LAVA_T);
    // Mountains extend to the screen bottom, so only their top edge matters.
    assign w_m1   = x_overlap({1'b0, mountain1_x}, c_MTN_W)
                    && (w_plane_bot > {1'b0, mountain1_y});
    assign w_m2   = x_overlap({1'b0, mountain2_x}, c_MTN_W)
                    && (w_plane_bot > {1'b0, mountain2_y});

    // Sampling stage: a one-cycle pulse, only raised on a PLAY tick.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_coll_q <= 1'b0;
            r_src_q  <= 2'b00;
        end else begin
            r_coll_q <= tick && (r_state == ST_PLAY) && (w_lava || w_m1 || w_m2);
            r_src_q  <= {w_m1 || w_m2, w_lava};
        end
    end

    // Action stage and game-state FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_game_over <= 1'b1;
            r_lives     <= c_LIVES;
            r_hit       <= 1'b0;
            r_hit_src   <= 2'b00;
            r_invuln    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        r_state     <= ST_PLAY;
                        r_game_over <= 1'b0;
                        r_lives     <= c_LIVES;
                        r_hit_src   <= 2'b00;
                        r_invuln    <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (r_coll_q) begin
                        r_hit     <= 1'b1;
                        r_hit_src <= r_src_q;
                        // Saturating decrement; the last life ends the game.
                        r_lives   <= (r_lives != 2'd0) ? (r_lives - 2'd1) : 2'd0;
                        if (r_lives <= 2'd1) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state  <= ST_GRACE;
                            r_invuln <= 1'b1;
                            r_cnt    <= c_GRACE;
                        end
                    end
                end
                ST_GRACE: begin
                    if (tick) begin
                        if (r_cnt <= c_ONE) begin
                            r_state  <= ST_PLAY;
                            r_invuln <= 1'b0;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt - c_ONE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_game_over <= 1'b1;
                end
            endcase
        end
    end

    assign game_over = r_game_over;
    assign state     = r_state;
    assign lives     = r_lives;
    assign hit       = r_hit;
    assign hit_src   = r_hit_src;
    assign invuln    = r_invuln;

endmodule
`default_nettype wire
